// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: bus widths, loader state encoding and opcodes.
// Imported by the RAM loader and by benches that build test programs.
package sap1_pkg;

    localparam int unsigned SAP_ADDR_W = 4;
    localparam int unsigned SAP_DATA_W = 8;
    localparam int unsigned SAP_DEPTH  = 16;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_LOAD  = 3'd1,
        LD_WRITE = 3'd2,
        LD_VADDR = 3'd3,
        LD_VCMP  = 3'd4,
        LD_DONE  = 3'd5,
        LD_ERROR = 3'd6
    } ld_state_e;

    // SAP-1 instruction opcodes (upper nibble of a program byte)
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/ram_loader.sv
// Streams program bytes into the SAP-1 RAM, optionally reads them back against
// a shadow copy, and holds the CPU idle while a pass is in progress.
module ram_loader
    import sap1_pkg::*;
#(
    parameter int unsigned ADDR_W = SAP_ADDR_W,
    parameter int unsigned DATA_W = SAP_DATA_W,
    parameter int unsigned DEPTH  = SAP_DEPTH,
    parameter int unsigned VERIFY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [DATA_W-1:0] shadow_q [DEPTH];
    logic [DATA_W-1:0] shadow_d [DEPTH];

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LD_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_addr_q  <= '0;
            shadow_q    <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_addr_q  <= err_addr_d;
            shadow_q    <= shadow_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_addr_d  = err_addr_q;
        shadow_d    = shadow_q;

        unique case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (start) begin
                    state_d    = LD_LOAD;
                    cnt_d      = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_addr_d = '0;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b1;
                    ram_addr_d = '0;
                end
            end

            LD_LOAD: begin
                if (in_valid && in_ready_q) begin
                    ram_addr_d       = cnt_q;
                    ram_wdata_d      = in_data;
                    ram_we_d         = 1'b1;
                    in_ready_d       = 1'b0;
                    shadow_d[cnt_q]  = in_data;
                    state_d          = LD_WRITE;
                end
            end

            LD_WRITE: begin
                if (cnt_q == LAST_ADDR) begin
                    cnt_d      = '0;
                    ram_addr_d = '0;
                    if (VERIFY != 0) begin
                        state_d = LD_VADDR;
                    end else begin
                        state_d = LD_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d      = cnt_q + ADDR_W'(1);
                    in_ready_d = 1'b1;
                    state_d    = LD_LOAD;
                end
            end

            // Address was set on entry; this cycle lets a registered RAM catch up
            LD_VADDR: begin
                ram_addr_d = cnt_q;
                state_d    = LD_VCMP;
            end

            LD_VCMP: begin
                if (ram_rdata != shadow_q[cnt_q]) begin
                    error_d    = 1'b1;
                    err_addr_d = cnt_q;
                    busy_d     = 1'b0;
                    ram_addr_d = '0;
                    state_d    = LD_ERROR;
                end else if (cnt_q == LAST_ADDR) begin
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    ram_addr_d = '0;
                    state_d    = LD_DONE;
                end else begin
                    cnt_d      = cnt_q + ADDR_W'(1);
                    ram_addr_d = cnt_q + ADDR_W'(1);
                    state_d    = LD_VADDR;
                end
            end

            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign cpu_hold  = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: a verifying and a non-verifying loader share
// one byte stream, each writing its own registered-read RAM model.
module tb_ram_loader;
    import sap1_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       in_ready, ram_we, busy, cpu_hold, done, error;
    logic [3:0] ram_addr, err_addr;
    logic [7:0] ram_wdata, ram_rdata;

    logic       in_ready_nv, ram_we_nv, busy_nv, cpu_hold_nv, done_nv, error_nv;
    logic [3:0] ram_addr_nv, err_addr_nv;
    logic [7:0] ram_wdata_nv, ram_rdata_nv;

    logic [7:0] mem    [16];
    logic [7:0] mem_nv [16];
    logic [7:0] prog   [16];
    logic       fault = 1'b0;
    logic       ram_clr = 1'b0;
    logic       mon_clr = 1'b0;
    logic [3:0] pc_nv = 4'd0;

    int cyc = 0;
    int c0 = 0;
    int we_cnt = 0, addr_bad = 0, gap_bad = 0, last_we = 0;
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    ram_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .cpu_hold(cpu_hold), .done(done),
        .error(error), .err_addr(err_addr)
    );

    ram_loader #(.VERIFY(0)) dut_nv (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_nv), .ram_we(ram_we_nv), .ram_addr(ram_addr_nv),
        .ram_wdata(ram_wdata_nv), .ram_rdata(ram_rdata_nv), .busy(busy_nv),
        .cpu_hold(cpu_hold_nv), .done(done_nv), .error(error_nv), .err_addr(err_addr_nv)
    );

    // RAM models with registered read; fault forces a bad read at address 9
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= (fault && ram_addr == 4'd9) ? 8'hFF : mem[ram_addr];
        if (ram_we_nv) mem_nv[ram_addr_nv] <= ram_wdata_nv;
        ram_rdata_nv <= mem_nv[ram_addr_nv];
        pc_nv <= cpu_hold_nv ? 4'd0 : pc_nv + 4'd1;
        cyc <= cyc + 1;
    end

    // Write-strobe monitor: pulse count, address order and spacing
    always @(posedge clk) begin
        if (mon_clr) begin
            we_cnt <= 0; addr_bad <= 0; gap_bad <= 0; last_we <= 0;
        end else if (ram_we) begin
            if (32'(ram_addr) != 32'(we_cnt % 16)) addr_bad <= addr_bad + 1;
            if (we_cnt != 0 && cyc - last_we != 2) gap_bad <= gap_bad + 1;
            last_we <= cyc;
            we_cnt  <= we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        mon_clr = 1'b1; start = 1'b1; c0 = cyc;
        @(negedge clk);
        mon_clr = 1'b0; start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1; in_data = b;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_end(output int lat);
        int n = 0;
        while (!done && !error && n < 300) begin @(negedge clk); n++; end
        if (!(done || error)) check("end_timeout", 32'(done | error), 32'd1);
        lat = cyc - c0 - 1;
    endtask

    function automatic int img_bad(input logic [7:0] base, input logic [7:0] step, input int last);
        int bad = 0;
        for (int i = 0; i <= last; i++) if (mem[i] !== 8'(base + step * 8'(i))) bad++;
        return bad;
    endfunction

    initial begin
        int lat, bad;
        prog[0] = {OP_LDA, 4'h9}; prog[1] = {OP_ADD, 4'hA}; prog[2] = {OP_SUB, 4'hB};
        prog[3] = {OP_OUT, 4'h0}; prog[4] = {OP_HLT, 4'h0};
        for (int i = 5; i < 16; i++) prog[i] = 8'(8'h10 + 8'(i));

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_busy_hold", 32'({busy, cpu_hold}), 0);
        check("rst_done_err", 32'({done, error, err_addr}), 0);
        check("rst_addr_wdata", 32'({ram_addr, ram_wdata}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full load, data 00..0F
        pulse_start();
        check("t1_start_flags", 32'({busy, cpu_hold, in_ready}), 32'b111);
        for (int k = 0; k < 16; k++) send_byte(8'(k));
        bad = 0;
        while (!done_nv && bad < 100) begin @(negedge clk); bad++; end
        check("t1_nv_latency", 32'(cyc - c0 - 1), 32'd32);
        check("t1_nv_status", 32'({done_nv, error_nv, busy_nv, cpu_hold_nv, in_ready_nv, err_addr_nv}), 32'h100);
        check("t1_nv_pc0", 32'(pc_nv), 0);
        repeat (3) @(negedge clk);
        check("t1_nv_pc3", 32'(pc_nv), 3);
        check("t1_nv_mem15", 32'(mem_nv[15]), 32'h0F);
        wait_end(lat);
        check("t1_latency", 32'(lat), 32'd64);
        check("t1_done_err", 32'({done, error}), 32'b10);
        check("t1_busy_addr", 32'({busy, cpu_hold, in_ready, ram_addr}), 0);
        check("t1_mem5", 32'(mem[5]), 32'h05);
        check("t1_we_gap", 32'(gap_bad), 0);
        check("t1_we_addr", 32'(addr_bad), 0);
        repeat (4) @(negedge clk);
        check("t1_we_cnt", 32'(we_cnt), 16);
        in_valid = 1'b0;

        // Back-pressure after byte 3
        ram_clr = 1'b1; @(negedge clk); ram_clr = 1'b0;
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(8'(k));
        in_valid = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if (!in_ready || ram_we) bad++;
            @(negedge clk);
        end
        check("t2_stall", 32'(bad), 0);
        check("t2_cnt", 32'(dut.cnt_q), 4);
        check("t2_we_cnt_stall", 32'(we_cnt), 4);
        for (int k = 4; k < 16; k++) send_byte(8'(k));
        wait_end(lat);
        check("t2_done", 32'({done, error}), 32'b10);
        check("t2_image", 32'(img_bad(8'h00, 8'h01, 15)), 0);
        check("t2_we", 32'({24'(we_cnt), 8'(addr_bad)}), 32'h1000);
        in_valid = 1'b0;

        // Verify fault at address 9
        fault = 1'b1;
        pulse_start();
        for (int k = 0; k < 16; k++) send_byte(8'(k));
        wait_end(lat);
        check("t3_err", 32'({done, error}), 32'b01);
        check("t3_err_addr", 32'(err_addr), 32'h9);
        check("t3_busy", 32'({busy, cpu_hold, ram_addr}), 0);
        check("t3_latency", 32'(lat), 32'd52);
        fault = 1'b0;
        in_valid = 1'b0;

        // Start pulsed mid-load is ignored
        pulse_start();
        check("t4_clear", 32'({done, error, err_addr}), 0);
        for (int k = 0; k < 7; k++) send_byte(prog[k]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_cnt", 32'(dut.cnt_q), 7);
        check("t4_busy", 32'(busy), 1);
        for (int k = 7; k < 16; k++) send_byte(prog[k]);
        wait_end(lat);
        check("t4_done", 32'({done, error}), 32'b10);
        check("t4_latency", 32'(lat), 32'd64);
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== prog[i]) bad++;
        check("t4_image", 32'(bad), 0);
        check("t4_we", 32'({24'(we_cnt), 8'(addr_bad)}), 32'h1000);
        in_valid = 1'b0;

        // Reset after byte 10, then a full reload of 8'h56
        pulse_start();
        for (int k = 0; k < 11; k++) send_byte(8'(8'h30 + 8'(k)));
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_outs", 32'({in_ready, ram_we, ram_addr, ram_wdata, busy, cpu_hold, done, error, err_addr}), 0);
        check("t5_kept", 32'(img_bad(8'h30, 8'h01, 10)), 0);
        check("t5_mem11", 32'(mem[11]), 32'(prog[11]));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        for (int k = 0; k < 16; k++) send_byte(8'h56);
        wait_end(lat);
        check("t5_done", 32'({done, error}), 32'b10);
        check("t5_image", 32'(img_bad(8'h56, 8'h00, 15)), 0);
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
